// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART: 8-deep TX/RX byte FIFOs, serializer/deserializer sharing one
// baud divider setting, combinational read data and a level RX interrupt.
//
// state    | meaning
// TX_IDLE  | line high, pops the next byte when the TX FIFO holds one
// TX_START | start bit (0) for one bit time
// TX_DATA  | eight data bits, LSB first
// TX_STOP  | stop bit (1) for one bit time
// RX_IDLE  | waiting for a synchronized low on uart_rx
// RX_START | half-bit delay, then confirm the start bit or reject a glitch
// RX_DATA  | eight samples one bit time apart, LSB first
// RX_STOP  | stop-bit sample: push the byte or flag a framing error
// RX_WAIT  | after a framing error, wait for the line to return high
module uart_bus_ctrl #(
    parameter int CLK_DIV = 5208,
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int PW = FIFO_AW + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    tx_state_t     tx_state_q, tx_state_d;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [7:0]    tx_mem_q [2**FIFO_AW];
    logic [7:0]    rx_mem_q [2**FIFO_AW];
    logic          tx_out_q, tx_out_d;
    logic          rx_s1_q, rx_s2_q;
    logic          rx_ie_q, rx_ie_d, rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d, irq_q, irq_d;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop, rx_stop_ok, rx_stop_bad;
    logic          wr_txdata, rd_rxdata, rd_status, wr_ctrl;
    logic          unused_bits;

    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:8]};

    assign wr_txdata = wr && (addr[3:2] == 2'd0);
    assign rd_rxdata = rd && (addr[3:2] == 2'd1);
    assign rd_status = rd && (addr[3:2] == 2'd2);
    assign wr_ctrl   = wr && (addr[3:2] == 2'd3);

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q == {~tx_rptr_q[FIFO_AW], tx_rptr_q[FIFO_AW-1:0]});
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q == {~rx_rptr_q[FIFO_AW], rx_rptr_q[FIFO_AW-1:0]});

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign tx_push = wr_txdata && (!tx_full || tx_pop);
    assign rx_pop  = rd_rxdata && !rx_empty;
    assign rx_push = rx_stop_ok && (!rx_full || rx_pop);

    assign tx_wptr_d = tx_wptr_q + PW'(tx_push);
    assign tx_rptr_d = tx_rptr_q + PW'(tx_pop);
    assign rx_wptr_d = rx_wptr_q + PW'(rx_push);
    assign rx_rptr_d = rx_rptr_q + PW'(rx_pop);

    // A new error event wins over a same-cycle STATUS read so it is never lost.
    assign rx_ovr_d    = (rx_ovr_q && !rd_status) || (rx_stop_ok && rx_full && !rx_pop);
    assign frame_err_d = (frame_err_q && !rd_status) || rx_stop_bad;
    assign rx_ie_d     = wr_ctrl ? wdata[0] : rx_ie_q;
    assign irq_d       = rx_ie_q && !rx_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q  <= TX_IDLE;
            rx_state_q  <= RX_IDLE;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            rx_bit_q    <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            tx_out_q    <= 1'b1;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_ie_q     <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            rx_state_q  <= rx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            rx_bit_q    <= rx_bit_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            tx_out_q    <= tx_out_d;
            rx_s1_q     <= uart_rx;
            rx_s2_q     <= rx_s1_q;
            rx_ie_q     <= rx_ie_d;
            rx_ovr_q    <= rx_ovr_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q[FIFO_AW-1:0]] <= wdata[7:0];
        if (rx_push) rx_mem_q[rx_wptr_q[FIFO_AW-1:0]] <= rx_shift_q;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = tx_mem_q[tx_rptr_q[FIFO_AW-1:0]];
                tx_cnt_d   = BIT_LAST;
                tx_state_d = TX_START;
            end
            TX_START: if (tx_cnt_q == '0) begin
                tx_cnt_d   = BIT_LAST;
                tx_bit_d   = 3'd0;
                tx_state_d = TX_DATA;
            end else tx_cnt_d = tx_cnt_q - CW'(1);
            TX_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d   = BIT_LAST;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            end else tx_cnt_d = tx_cnt_q - CW'(1);
            TX_STOP: if (tx_cnt_q == '0) tx_state_d = TX_IDLE;
                     else tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_stop_ok  = 1'b0;
        rx_stop_bad = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (!rx_s2_q) begin
                rx_cnt_d   = HALF_LAST;
                rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == '0) begin
                if (rx_s2_q) rx_state_d = RX_IDLE;
                else begin
                    rx_cnt_d   = BIT_LAST;
                    rx_bit_d   = 3'd0;
                    rx_state_d = RX_DATA;
                end
            end else rx_cnt_d = rx_cnt_q - CW'(1);
            RX_DATA: if (rx_cnt_q == '0) begin
                rx_cnt_d   = BIT_LAST;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end else rx_cnt_d = rx_cnt_q - CW'(1);
            RX_STOP: if (rx_cnt_q == '0) begin
                if (rx_s2_q) begin
                    rx_stop_ok = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_stop_bad = 1'b1;
                    rx_state_d  = RX_WAIT;
                end
            end else rx_cnt_d = rx_cnt_q - CW'(1);
            RX_WAIT: if (rx_s2_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_out_d = 1'b1;
        case (tx_state_q)
            TX_START: tx_out_d = 1'b0;
            TX_DATA:  tx_out_d = tx_shift_q[0];
            default:  tx_out_d = 1'b1;
        endcase
        rdata = '0;
        if (rd) begin
            case (addr[3:2])
                2'd1:    if (!rx_empty) rdata = {24'b0, rx_mem_q[rx_rptr_q[FIFO_AW-1:0]]};
                2'd2:    rdata = {27'b0, frame_err_q, rx_ovr_q, !rx_empty,
                                  tx_empty && (tx_state_q == TX_IDLE), tx_full};
                2'd3:    rdata = {31'b0, rx_ie_q};
                default: rdata = '0;
            endcase
        end
    end

    assign uart_tx = tx_out_q;
    assign irq     = irq_q;
endmodule
